// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, 16-bit ALU, branch resolve, EXE/MEM output latch on falling edge.
// Optional EXE_MUL_EN adds an iterative shift-add multiplier (aluop F) that raises busy_out.
module exe_stage #(
    parameter logic [3:0] NOREG   = 4'hF,
    parameter int         MUL_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic [15:0] rdata1,
    input  logic [15:0] rdata2,
    input  logic [15:0] imme,
    input  logic [15:0] pc,
    input  logic [3:0]  rreg1,
    input  logic [3:0]  rreg2,
    input  logic [3:0]  wreg,
    input  logic [3:0]  aluop,
    input  logic [1:0]  controlb,
    input  logic        ifjump,
    input  logic [1:0]  jorb,
    input  logic [1:0]  controlmem,
    input  logic        controlwb,
    input  logic [3:0]  mem_wreg,
    input  logic [3:0]  wb_wreg,
    input  logic [15:0] mem_wdata,
    input  logic [15:0] wb_wdata,
    input  logic        mem_wen,
    input  logic        wb_wen,
    output logic [15:0] alu_res_out,
    output logic [15:0] memdata_out,
    output logic [3:0]  wreg_out,
    output logic [1:0]  controlmem_out,
    output logic        controlwb_out,
    output logic        jump_out,
    output logic [15:0] jump_target_out,
    output logic        busy_out
);
    logic [15:0] fa, fb, op_a, op_b, alu_y, mul_res;
    logic        taken, busy, mul_done;
    logic [15:0] jtgt;

    logic [15:0] alu_res_q, memdata_q, jump_target_q;
    logic [3:0]  wreg_q;
    logic [1:0]  controlmem_q;
    logic        controlwb_q, jump_q;

    always_comb begin
        fa = rdata1;
        if (mem_wen && mem_wreg == rreg1 && rreg1 != NOREG)     fa = mem_wdata;
        else if (wb_wen && wb_wreg == rreg1 && rreg1 != NOREG)  fa = wb_wdata;
        fb = rdata2;
        if (mem_wen && mem_wreg == rreg2 && rreg2 != NOREG)     fb = mem_wdata;
        else if (wb_wen && wb_wreg == rreg2 && rreg2 != NOREG)  fb = wb_wdata;
    end

    always_comb begin
        op_a = fa;
        op_b = fb;
        case (controlb)
            2'b00: begin op_a = fa; op_b = fb;    end
            2'b01: begin op_a = fa; op_b = imme;  end
            2'b10: begin op_a = pc; op_b = imme;  end
            default: begin op_a = fa; op_b = 16'h0; end
        endcase
    end

    always_comb begin
        alu_y = 16'h0;
        case (aluop)
            4'h0: alu_y = op_a + op_b;
            4'h1: alu_y = op_a - op_b;
            4'h2: alu_y = op_a & op_b;
            4'h3: alu_y = op_a | op_b;
            4'h4: alu_y = op_a ^ op_b;
            4'h5: alu_y = ~op_a;
            4'h6: alu_y = op_a << op_b[3:0];
            4'h7: alu_y = op_a >> op_b[3:0];
            4'h8: alu_y = $unsigned($signed(op_a) >>> op_b[3:0]);
            4'h9: alu_y = {15'h0, $signed(op_a) < $signed(op_b)};
            4'hA: alu_y = {15'h0, op_a < op_b};
            4'hB: alu_y = {15'h0, op_a != op_b};
            4'hC: alu_y = op_b;
            default: alu_y = 16'h0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        jtgt  = pc + imme;
        if (ifjump) begin
            case (jorb)
                2'b00: taken = 1'b1;
                2'b01: begin taken = 1'b1; jtgt = fa; end
                2'b10: taken = (fa == 16'h0);
                default: taken = (fa != 16'h0);
            endcase
        end
    end

`ifdef EXE_MUL_EN
    localparam int CW = $clog2(MUL_CYC);
    typedef enum logic [1:0] {IDLE, MUL, DONE} mul_state_t;

    mul_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, addend;

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= 16'h0;
            mplier_q <= 16'h0;
            acc_q    <= 16'h0;
        end else if (!stall_in) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    // The last partial product is folded in during DONE, so IDLE plus MUL spans MUL_CYC busy cycles.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        busy     = 1'b0;
        mul_done = 1'b0;
        addend   = mplier_q[0] ? mcand_q : 16'h0;
        mul_res  = acc_q + addend;
        case (state_q)
            IDLE: if (aluop == 4'hF) begin
                busy     = 1'b1;
                state_d  = MUL;
                cnt_d    = CW'(MUL_CYC - 1);
                mcand_d  = fa;
                mplier_d = fb;
                acc_d    = 16'h0;
            end
            MUL: begin
                busy     = 1'b1;
                acc_d    = acc_q + addend;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_d == '0) state_d = MUL == MUL ? DONE : DONE;
            end
            default: begin
                mul_done = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end
`else
    assign busy     = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = 16'h0;
`endif

    always_ff @(negedge clk) begin
        if (rst) begin
            alu_res_q     <= 16'h0;
            memdata_q     <= 16'h0;
            jump_target_q <= 16'h0;
            wreg_q        <= NOREG;
            controlmem_q  <= 2'b11;
            controlwb_q   <= 1'b0;
            jump_q        <= 1'b0;
        end else if (stall_in) begin
            jump_q <= 1'b0;
        end else if (busy) begin
            wreg_q       <= NOREG;
            controlmem_q <= 2'b11;
            controlwb_q  <= 1'b0;
            jump_q       <= 1'b0;
        end else begin
            alu_res_q     <= mul_done ? mul_res : alu_y;
            memdata_q     <= fb;
            jump_target_q <= jtgt;
            wreg_q        <= wreg;
            controlmem_q  <= controlmem;
            controlwb_q   <= controlwb;
            jump_q        <= taken;
        end
    end

    assign alu_res_out     = alu_res_q;
    assign memdata_out     = memdata_q;
    assign jump_target_out = jump_target_q;
    assign wreg_out        = wreg_q;
    assign controlmem_out  = controlmem_q;
    assign controlwb_out   = controlwb_q;
    assign jump_out        = jump_q;
    assign busy_out        = busy;
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage; inputs change and outputs are sampled 1ns after each falling edge.
module tb_exe_stage;
    logic        clk = 1'b0;
    logic        rst, stall_in, ifjump, controlwb, mem_wen, wb_wen;
    logic [15:0] rdata1, rdata2, imme, pc, mem_wdata, wb_wdata;
    logic [3:0]  rreg1, rreg2, wreg, aluop, mem_wreg, wb_wreg;
    logic [1:0]  controlb, jorb, controlmem;
    logic [15:0] alu_res_out, memdata_out, jump_target_out;
    logic [3:0]  wreg_out;
    logic [1:0]  controlmem_out;
    logic        controlwb_out, jump_out, busy_out;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .rdata1(rdata1), .rdata2(rdata2),
        .imme(imme), .pc(pc), .rreg1(rreg1), .rreg2(rreg2), .wreg(wreg), .aluop(aluop),
        .controlb(controlb), .ifjump(ifjump), .jorb(jorb), .controlmem(controlmem),
        .controlwb(controlwb), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
        .mem_wdata(mem_wdata), .wb_wdata(wb_wdata), .mem_wen(mem_wen), .wb_wen(wb_wen),
        .alu_res_out(alu_res_out), .memdata_out(memdata_out), .wreg_out(wreg_out),
        .controlmem_out(controlmem_out), .controlwb_out(controlwb_out),
        .jump_out(jump_out), .jump_target_out(jump_target_out), .busy_out(busy_out)
    );

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; stall_in = 0; rdata1 = 0; rdata2 = 0; imme = 0; pc = 0;
        rreg1 = 4'hF; rreg2 = 4'hF; wreg = 4'hF; aluop = 0; controlb = 0;
        ifjump = 0; jorb = 0; controlmem = 2'b11; controlwb = 0;
        mem_wreg = 4'hF; wb_wreg = 4'hF; mem_wdata = 0; wb_wdata = 0; mem_wen = 0; wb_wen = 0;
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if ({alu_res_out, memdata_out, jump_target_out} !== 48'h0 || wreg_out !== 4'hF ||
            controlmem_out !== 2'b11 || controlwb_out !== 1'b0 || jump_out !== 1'b0 || busy_out !== 1'b0) begin
            n_errors++;
            $display("FAIL %s: alu=%h md=%h tgt=%h wreg=%h cm=%b wb=%b j=%b busy=%b, want 0/0/0/f/11/0/0/0",
                     tag, alu_res_out, memdata_out, jump_target_out, wreg_out, controlmem_out,
                     controlwb_out, jump_out, busy_out);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; rreg1 = 1; rdata1 = 16'h1234; wreg = 2; controlmem = 0; controlwb = 1; ifjump = 1;
        step();
        check_reset_values("reset");
        idle_inputs();
    endtask

    task automatic test_forward();
        idle_inputs();
        rreg1 = 3; rdata1 = 5; mem_wreg = 3; mem_wen = 1; mem_wdata = 7;
        rreg2 = 5; rdata2 = 16'h0055; controlb = 2'b01; imme = 2; aluop = 0;
        wreg = 2; controlmem = 2'b01; controlwb = 1;
        step();
        n_checks++;
        if (alu_res_out !== 16'h0009 || memdata_out !== 16'h0055 || wreg_out !== 4'h2 ||
            controlmem_out !== 2'b01 || controlwb_out !== 1'b1) begin
            n_errors++;
            $display("FAIL add_fwd: alu=%h md=%h wreg=%h cm=%b wb=%b, want 0009 0055 2 01 1",
                     alu_res_out, memdata_out, wreg_out, controlmem_out, controlwb_out);
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        rreg1 = 4; rdata1 = 16'h0099; controlb = 2'b11; aluop = 0;
        mem_wreg = 4; mem_wen = 1; mem_wdata = 16'h0011;
        wb_wreg = 4; wb_wen = 1; wb_wdata = 16'h0022;
        rreg2 = 4; rdata2 = 16'h0077;
        step();
        n_checks++;
        if (alu_res_out !== 16'h0011 || memdata_out !== 16'h0011) begin
            n_errors++;
            $display("FAIL mem_over_wb: alu=%h md=%h, want 0011 0011", alu_res_out, memdata_out);
        end
        mem_wen = 0;
        step();
        n_checks++;
        if (alu_res_out !== 16'h0022) begin
            n_errors++;
            $display("FAIL wb_fwd: alu=%h, want 0022", alu_res_out);
        end
        rreg1 = 4'hF; rreg2 = 4'hF; rdata1 = 16'h0033; rdata2 = 16'h0044;
        mem_wreg = 4'hF; mem_wen = 1; wb_wreg = 4'hF; wb_wen = 1;
        step();
        n_checks++;
        if (alu_res_out !== 16'h0033 || memdata_out !== 16'h0044) begin
            n_errors++;
            $display("FAIL noreg_nofwd: alu=%h md=%h, want 0033 0044", alu_res_out, memdata_out);
        end
    endtask

    task automatic test_branch();
        idle_inputs();
        ifjump = 1; jorb = 2'b10; rreg1 = 1; rdata1 = 0; pc = 16'h0010; imme = 16'hFFFE;
        step();
        n_checks++;
        if (jump_out !== 1'b1 || jump_target_out !== 16'h000E) begin
            n_errors++;
            $display("FAIL beqz_taken: j=%b tgt=%h, want 1 000e", jump_out, jump_target_out);
        end
        ifjump = 0;
        step();
        n_checks++;
        if (jump_out !== 1'b0) begin
            n_errors++;
            $display("FAIL jump_pulse_width: j=%b, want 0", jump_out);
        end
        ifjump = 1; rdata1 = 1;
        step();
        n_checks++;
        if (jump_out !== 1'b0) begin
            n_errors++;
            $display("FAIL beqz_not_taken: j=%b, want 0", jump_out);
        end
        jorb = 2'b11;
        step();
        n_checks++;
        if (jump_out !== 1'b1 || jump_target_out !== 16'h000E) begin
            n_errors++;
            $display("FAIL bnez_taken: j=%b tgt=%h, want 1 000e", jump_out, jump_target_out);
        end
        jorb = 2'b01; rdata1 = 16'h1234;
        step();
        n_checks++;
        if (jump_out !== 1'b1 || jump_target_out !== 16'h1234) begin
            n_errors++;
            $display("FAIL jr_target: j=%b tgt=%h, want 1 1234", jump_out, jump_target_out);
        end
    endtask

    task automatic test_alu();
        logic [3:0]  op  [15] = '{4'h8, 4'h9, 4'hA, 4'h1, 4'h0, 4'h2, 4'h3, 4'h4,
                                  4'h5, 4'h6, 4'h7, 4'hB, 4'hB, 4'hC, 4'hD};
        logic [15:0] va  [15] = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hF0F0,
                                  16'hF000, 16'hFF00, 16'h00FF, 16'h0001, 16'h8000, 16'h0005,
                                  16'h0005, 16'h1234, 16'h1234};
        logic [15:0] vb  [15] = '{16'h0003, 16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h0FF0,
                                  16'h000F, 16'h0FF0, 16'h1234, 16'h0004, 16'h000F, 16'h0005,
                                  16'h0006, 16'hABCD, 16'h5678};
        logic [15:0] exp [15] = '{16'hF000, 16'h0001, 16'h0000, 16'hFFFF, 16'h0001, 16'h00F0,
                                  16'hF00F, 16'hF0F0, 16'hFF00, 16'h0010, 16'h0001, 16'h0000,
                                  16'h0001, 16'hABCD, 16'h0000};
        idle_inputs();
        rreg1 = 1; rreg2 = 2;
        for (int i = 0; i < 15; i++) begin
            aluop = op[i]; rdata1 = va[i]; rdata2 = vb[i];
            step();
            n_checks++;
            if (alu_res_out !== exp[i]) begin
                n_errors++;
                $display("FAIL alu_op%h_%0d: got %h, want %h", op[i], i, alu_res_out, exp[i]);
            end
        end
`ifndef EXE_MUL_EN
        aluop = 4'hF; rdata1 = 16'h0012; rdata2 = 16'h0034;
        #1;
        n_checks++;
        if (busy_out !== 1'b0) begin
            n_errors++;
            $display("FAIL mul_off_busy: got %b, want 0", busy_out);
        end
        step();
        n_checks++;
        if (alu_res_out !== 16'h0000) begin
            n_errors++;
            $display("FAIL mul_off_zero: got %h, want 0000", alu_res_out);
        end
`endif
    endtask

    task automatic test_stall();
        idle_inputs();
        rreg1 = 1; rdata1 = 1; rreg2 = 2; rdata2 = 2; wreg = 5; controlwb = 1; controlmem = 2'b11;
        ifjump = 1; jorb = 2'b00; pc = 16'h0100; imme = 16'h0004;
        step();
        n_checks++;
        if (alu_res_out !== 16'h0003 || jump_out !== 1'b1 || jump_target_out !== 16'h0104) begin
            n_errors++;
            $display("FAIL stall_load: alu=%h j=%b tgt=%h, want 0003 1 0104", alu_res_out, jump_out, jump_target_out);
        end
        stall_in = 1; rdata1 = 9; wreg = 7; pc = 16'h0200;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (alu_res_out !== 16'h0003 || wreg_out !== 4'h5 || jump_out !== 1'b0 ||
                jump_target_out !== 16'h0104 || controlwb_out !== 1'b1) begin
                n_errors++;
                $display("FAIL stall_hold_%0d: alu=%h wreg=%h j=%b tgt=%h wb=%b, want 0003 5 0 0104 1",
                         i, alu_res_out, wreg_out, jump_out, jump_target_out, controlwb_out);
            end
        end
        stall_in = 0; ifjump = 0;
        step();
        n_checks++;
        if (alu_res_out !== 16'h000B || wreg_out !== 4'h7 || jump_out !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_release: alu=%h wreg=%h j=%b, want 000b 7 0", alu_res_out, wreg_out, jump_out);
        end
        rst = 1; ifjump = 1;
        step();
        check_reset_values("reset_mid");
        idle_inputs();
    endtask

    task automatic test_bubble();
        idle_inputs();
        rreg1 = 1; rdata1 = 16'h0040; imme = 16'h0002; controlb = 2'b01; ifjump = 1; jorb = 2'b00;
        pc = 16'h0020;
        step();
        n_checks++;
        if (wreg_out !== 4'hF || controlmem_out !== 2'b11 || controlwb_out !== 1'b0 ||
            jump_out !== 1'b1 || alu_res_out !== 16'h0042 || jump_target_out !== 16'h0022) begin
            n_errors++;
            $display("FAIL bubble: wreg=%h cm=%b wb=%b j=%b alu=%h tgt=%h, want f 11 0 1 0042 0022",
                     wreg_out, controlmem_out, controlwb_out, jump_out, alu_res_out, jump_target_out);
        end
    endtask

`ifdef EXE_MUL_EN
    task automatic test_mul();
        int busy_cnt;
        logic bad_bubble;
        idle_inputs();
        rreg1 = 1; rdata1 = 16'h0012; rreg2 = 2; rdata2 = 16'h0034;
        aluop = 4'hF; wreg = 6; controlwb = 1; controlmem = 2'b11;
        #1;
        busy_cnt = busy_out ? 1 : 0;
        bad_bubble = 1'b0;
        for (int i = 0; i < 40 && busy_out === 1'b1; i++) begin
            step();
            if (wreg_out !== 4'hF || controlwb_out !== 1'b0) bad_bubble = 1'b1;
            if (busy_out === 1'b1) busy_cnt++;
        end
        n_checks++;
        if (busy_cnt != 16 || bad_bubble) begin
            n_errors++;
            $display("FAIL mul_busy: busy cycles=%0d bubble_err=%b, want 16 0", busy_cnt, bad_bubble);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (alu_res_out !== 16'h03A8 || wreg_out !== 4'h6 || controlwb_out !== 1'b1 || busy_out !== 1'b0) begin
            n_errors++;
            $display("FAIL mul_result: alu=%h wreg=%h wb=%b busy=%b, want 03a8 6 1 0",
                     alu_res_out, wreg_out, controlwb_out, busy_out);
        end
        rreg1 = 1; rdata1 = 16'h0012; rreg2 = 2; rdata2 = 16'h0034; aluop = 4'hF; wreg = 6; controlwb = 1;
        repeat (5) step();
        idle_inputs();
        rst = 1;
        step();
        check_reset_values("mul_reset");
        rst = 0;
        repeat (3) step();
        check_reset_values("mul_no_write");
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_priority();
        test_branch();
        test_alu();
        test_stall();
        test_bubble();
`ifdef EXE_MUL_EN
        test_mul();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
